regwrite_arbiter: RTL

REGWRITE_ARBITER -- requirements
Module: regwrite_arbiter

---
 rtl/regwrite_arbiter.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/regwrite_arbiter.sv
// ============================================================================
// regwrite_arbiter
//
// Arbitrates four register-file write-back requesters onto one write port and
// drives the destination select for the register-file address mux.
//
//   Requester  Grant bit  WriteRegCtrl  Destination
//   Rd         0          2'b00         rd  (instruction bits 15:11)
//   Sp         1          2'b01         r29 (stack pointer)
//   Ra         2          2'b10         r31 (link register)
//   Rt         3          2'b11         rt  (instruction bits 20:16)
//
// Winner selection: fixed priority Ra > Sp > Rt > Rd, except that any
// requester whose wait counter has reached STARVE_LIMIT (starved) beats all
// non-starved requesters. Ties among starved requesters use the same order.
//
// Parameters
//   STARVE_LIMIT  wait cycles (1..7) after which a pending requester is starved
//
// Ports
//   clk           sole clock, rising edge
//   reset_n       asynchronous active-low reset
//   ReqRd/ReqSp/ReqRa/ReqRt  level write-back requests, held until Grant
//   Rd_field      instruction bits 15:11
//   Rt_field      instruction bits 20:16
//   Stall         freezes write-back while high
//   WriteRegCtrl  destination select (table above), held while idle
//   RegWrite      register-file write strobe
//   Grant         one-hot acknowledge (table above)
//   Busy          high whenever the FSM is not idle
//
// Optional feature
//   REGWRITE_R0_FILTER_EN  when defined, a granted Rd or Rt write whose
//                          destination field is 0 still pulses Grant but keeps
//                          RegWrite low (writes to r0 are suppressed).
// ============================================================================
module regwrite_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ReqRd,
    input  logic       ReqSp,
    input  logic       ReqRa,
    input  logic       ReqRt,
    input  logic [4:0] Rd_field,
    input  logic [4:0] Rt_field,
    input  logic       Stall,
    output logic [1:0] WriteRegCtrl,
    output logic       RegWrite,
    output logic [3:0] Grant,
    output logic       Busy
);

    // state   | meaning
    // --------+------------------------------------------------------------
    // S_IDLE  | no write in flight; WriteRegCtrl holds its last value
    // S_WRITE | winner latched; a cycle with Grant set is the write pulse,
    //         | a cycle with Grant clear is a stalled (pending) write
    typedef enum logic {
        S_IDLE  = 1'b0,
        S_WRITE = 1'b1
    } state_t;

    localparam logic [2:0] LIMIT  = 3'(STARVE_LIMIT);
    localparam logic [1:0] CODE_RD = 2'd0;
    localparam logic [1:0] CODE_RT = 2'd3;

`ifdef REGWRITE_R0_FILTER_EN
    localparam bit FILTER_EN = 1'b1;
`else
    localparam bit FILTER_EN = 1'b0;
`endif

    state_t     r_state;
    logic [1:0] r_winner;
    logic [1:0] r_wrc;
    logic       r_regwrite;
    logic [3:0] r_grant;
    logic       r_busy;
    logic [2:0] r_cnt [4];

    logic [3:0] w_req;
    logic       w_complete;
    logic [3:0] w_cand;
    logic [3:0] w_starved;
    logic [3:0] w_pool;
    logic       w_any;
    logic [1:0] w_next_code;
    logic       w_drop_next;
    logic       w_drop_win;

    // Priority pick; bit index equals the WriteRegCtrl code.
    function automatic logic [1:0] pick(input logic [3:0] pool);
        logic [1:0] code;
        if (pool[2])      code = 2'd2;
        else if (pool[1]) code = 2'd1;
        else if (pool[3]) code = 2'd3;
        else              code = 2'd0;
        return code;
    endfunction

    // True when a write to this destination must be suppressed (r0 target).
    function automatic logic zero_dest(input logic [1:0] code,
                                       input logic [4:0] rd_f,
                                       input logic [4:0] rt_f);
        return FILTER_EN && (((code == CODE_RD) && (rd_f == 5'd0)) ||
                             ((code == CODE_RT) && (rt_f == 5'd0)));
    endfunction

    assign w_req      = {ReqRt, ReqRa, ReqSp, ReqRd};
    // The pulse cycle is the one that ends a write; its grantee sits out the
    // selection taking place on the same edge.
    assign w_complete = (r_state == S_WRITE) && (|r_grant);
    assign w_cand     = w_req & ~(w_complete ? r_grant : 4'b0000);

    always_comb begin
        w_starved = '0;
        for (int i = 0; i < 4; i++) begin
            w_starved[i] = w_cand[i] && (r_cnt[i] == LIMIT);
        end
    end

    assign w_pool      = (|w_starved) ? w_starved : w_cand;
    assign w_any       = |w_cand;
    assign w_next_code = pick(w_pool);
    assign w_drop_next = zero_dest(w_next_code, Rd_field, Rt_field);
    assign w_drop_win  = zero_dest(r_winner, Rd_field, Rt_field);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_winner   <= 2'd0;
            r_wrc      <= 2'd0;
            r_regwrite <= 1'b0;
            r_grant    <= 4'b0000;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_grant    <= 4'b0000;
                    r_regwrite <= 1'b0;
                    if (w_any && !Stall) begin
                        r_state    <= S_WRITE;
                        r_busy     <= 1'b1;
                        r_winner   <= w_next_code;
                        r_wrc      <= w_next_code;
                        r_grant    <= 4'b0001 << w_next_code;
                        r_regwrite <= !w_drop_next;
                    end
                end
                S_WRITE: begin
                    if (w_complete) begin
                        if (w_any) begin
                            // Back-to-back write; may start out stalled.
                            r_winner <= w_next_code;
                            r_wrc    <= w_next_code;
                            if (!Stall) begin
                                r_grant    <= 4'b0001 << w_next_code;
                                r_regwrite <= !w_drop_next;
                            end else begin
                                r_grant    <= 4'b0000;
                                r_regwrite <= 1'b0;
                            end
                        end else begin
                            r_state    <= S_IDLE;
                            r_busy     <= 1'b0;
                            r_grant    <= 4'b0000;
                            r_regwrite <= 1'b0;
                        end
                    end else begin
                        // Stalled write: the latched winner completes even if
                        // its request has since dropped.
                        if (!Stall) begin
                            r_grant    <= 4'b0001 << r_winner;
                            r_regwrite <= !w_drop_win;
                        end else begin
                            r_grant    <= 4'b0000;
                            r_regwrite <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_busy     <= 1'b0;
                    r_grant    <= 4'b0000;
                    r_regwrite <= 1'b0;
                end
            endcase
        end
    end

    // Wait counters: count cycles spent requesting without a grant.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                r_cnt[i] <= 3'd0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (!w_req[i] || r_grant[i]) begin
                    r_cnt[i] <= 3'd0;
                end else if (r_cnt[i] != LIMIT) begin
                    r_cnt[i] <= r_cnt[i] + 3'd1;
                end
            end
        end
    end

    assign WriteRegCtrl = r_wrc;
    assign RegWrite     = r_regwrite;
    assign Grant        = r_grant;
    assign Busy         = r_busy;

endmodule
